// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage feeding the IF/ID pipeline register
//
// Purpose: holds the fetch PC, issues requests to instruction memory over a
// req/ack handshake and presents a registered PC_plus_4/IR pair that IF/ID
// captures every cycle. Load-use stalls re-present the same instruction
// (IF/ID has no enable); redirects insert bubbles and discard in-flight data.
//
// Ports:
//   clk            in   1   clock
//   reset          in   1   asynchronous, active-high reset
//   stall          in   1   hold current IR/PC_plus_4
//   redirect_valid in   1   taken branch/jump: flush and refetch
//   redirect_pc    in  32   redirect target (bits [1:0] ignored)
//   imem_req       out  1   fetch request
//   imem_addr      out 32   fetch address, stable until ack
//   imem_ack       in   1   imem_rdata valid this cycle
//   imem_rdata     in  32   fetched instruction
//   PC_plus_4      out 32   address of presented instruction + 4
//   IR             out 32   presented instruction
//   fetch_valid    out  1   1 = IR is a real instruction, 0 = bubble

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_plus_4,
    output logic [31:0] IR,
    output logic        fetch_valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] pending_pc, pending_pc_n;
    logic [31:0] hold_ir, hold_ir_n;
    logic [31:0] hold_pc4, hold_pc4_n;
    logic [31:0] ir_n;
    logic [31:0] pc_plus_4_n;
    logic        fetch_valid_n;

    logic        req_raw;
    logic        ack;
    logic [31:0] pc_inc;
    logic [31:0] target_pc;

    assign req_raw   = (state == S_FETCH) || (state == S_DROP);
    assign imem_req  = req_raw && !reset;
    assign imem_addr = fetch_pc;

    // An ack only means something while a request is outstanding.
    assign ack       = imem_ack && req_raw;
    assign pc_inc    = fetch_pc + 32'd4;
    assign target_pc = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            fetch_pc    <= RESET_PC;
            pending_pc  <= 32'd0;
            hold_ir     <= 32'd0;
            hold_pc4    <= 32'd0;
            IR          <= NOP_INSTR;
            PC_plus_4   <= 32'd0;
            fetch_valid <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            pending_pc  <= pending_pc_n;
            hold_ir     <= hold_ir_n;
            hold_pc4    <= hold_pc4_n;
            IR          <= ir_n;
            PC_plus_4   <= pc_plus_4_n;
            fetch_valid <= fetch_valid_n;
        end
    end

    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        pending_pc_n  = pending_pc;
        hold_ir_n     = hold_ir;
        hold_pc4_n    = hold_pc4;
        ir_n          = IR;
        pc_plus_4_n   = PC_plus_4;
        fetch_valid_n = fetch_valid;

        if (redirect_valid) begin
            // Redirect always bubbles, even under stall: the instruction
            // currently in IF/ID is on the wrong path.
            ir_n          = NOP_INSTR;
            fetch_valid_n = 1'b0;
            case (state)
                S_FETCH: begin
                    if (ack) begin
                        fetch_pc_n = target_pc;
                    end else begin
                        // Request is already on the bus; address must stay
                        // put until the memory answers, so park the target.
                        pending_pc_n = target_pc;
                        state_n      = S_DROP;
                    end
                end
                S_HOLD: begin
                    fetch_pc_n = target_pc;
                    state_n    = S_FETCH;
                end
                S_DROP: begin
                    if (ack) begin
                        fetch_pc_n = target_pc;
                        state_n    = S_FETCH;
                    end else begin
                        pending_pc_n = target_pc;
                    end
                end
                default: begin
                    fetch_pc_n = target_pc;
                    state_n    = S_FETCH;
                end
            endcase
        end else begin
            case (state)
                S_FETCH: begin
                    if (ack) begin
                        fetch_pc_n = pc_inc;
                        if (stall) begin
                            // Outputs frozen; park the new instruction.
                            hold_ir_n  = imem_rdata;
                            hold_pc4_n = pc_inc;
                            state_n    = S_HOLD;
                        end else begin
                            ir_n          = imem_rdata;
                            pc_plus_4_n   = pc_inc;
                            fetch_valid_n = 1'b1;
                        end
                    end else if (!stall) begin
                        ir_n          = NOP_INSTR;
                        fetch_valid_n = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ir_n          = hold_ir;
                        pc_plus_4_n   = hold_pc4;
                        fetch_valid_n = 1'b1;
                        state_n       = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (ack) begin
                        fetch_pc_n = pending_pc;
                        state_n    = S_FETCH;
                    end
                    if (!stall) begin
                        ir_n          = NOP_INSTR;
                        fetch_valid_n = 1'b0;
                    end
                end
                default: begin
                    state_n = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit

module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] PC_plus_4;
    logic [31:0] IR;
    logic        fetch_valid;

    int tests_run = 0;
    int tests_failed = 0;

    if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .PC_plus_4(PC_plus_4), .IR(IR), .fetch_valid(fetch_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [31:0] addr, input logic stl,
                         input logic rv, input logic [31:0] rpc);
        imem_ack       = ack;
        imem_rdata     = mem(addr);
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        tests_run++; if (IR !== NOP) begin tests_failed++; $display("FAIL reset_ir got %h exp %h", IR, NOP); end
        tests_run++; if (fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_fv got %b exp 0", fetch_valid); end
        tests_run++; if (PC_plus_4 !== 32'd0) begin tests_failed++; $display("FAIL reset_pc4 got %h exp 0", PC_plus_4); end
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got %b exp 0", imem_req); end
        reset = 1'b0;
        #1;
        tests_run++; if (imem_addr !== RST_PC) begin tests_failed++; $display("FAIL reset_addr got %h exp %h", imem_addr, RST_PC); end
    endtask

    task automatic test_zero_wait();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = 32'(4 * k);
            drive(1'b1, a, 1'b0, 1'b0, 32'd0);
            #1;
            tests_run++; if (imem_req !== 1'b1 || imem_addr !== a) begin tests_failed++; $display("FAIL zw_addr got %b/%h exp 1/%h", imem_req, imem_addr, a); end
            step();
            tests_run++; if (IR !== mem(a) || PC_plus_4 !== a + 32'd4 || fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL zw_out got %h/%h/%b exp %h/%h/1", IR, PC_plus_4, fetch_valid, mem(a), a + 32'd4); end
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'd0);
        step();
        for (int c = 0; c < 3; c++) begin
            tests_run++; if (IR !== mem(32'hC) || PC_plus_4 !== 32'h10 || fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_frozen got %h/%h/%b exp %h/00000010/1", IR, PC_plus_4, fetch_valid, mem(32'hC)); end
            tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_noreq got %b exp 0", imem_req); end
            // Stray ack while no request is outstanding must be ignored.
            drive(1'b1, 32'h999, (c < 2), 1'b0, 32'd0);
            step();
        end
        tests_run++; if (IR !== mem(32'h10) || PC_plus_4 !== 32'h14 || fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_release got %h/%h/%b exp %h/00000014/1", IR, PC_plus_4, fetch_valid, mem(32'h10)); end
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin tests_failed++; $display("FAIL stall_next got %b/%h exp 1/00000014", imem_req, imem_addr); end
    endtask

    task automatic test_latency();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] a;
            a = 32'h14 + 32'(4 * k);
            drive(1'b0, a, 1'b0, 1'b0, 32'd0);
            step();
            tests_run++; if (IR !== NOP || fetch_valid !== 1'b0 || PC_plus_4 !== a) begin tests_failed++; $display("FAIL lat_bubble got %h/%b/%h exp %h/0/%h", IR, fetch_valid, PC_plus_4, NOP, a); end
            tests_run++; if (imem_addr !== a || imem_req !== 1'b1) begin tests_failed++; $display("FAIL lat_addr got %h exp %h", imem_addr, a); end
            drive(1'b1, a, 1'b0, 1'b0, 32'd0);
            step();
            tests_run++; if (IR !== mem(a) || PC_plus_4 !== a + 32'd4 || fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_data got %h/%h/%b exp %h/%h/1", IR, PC_plus_4, fetch_valid, mem(a), a + 32'd4); end
        end
        drive(1'b1, 32'h1C, 1'b0, 1'b0, 32'd0);
        step();
    endtask

    task automatic test_redirect();
        drive(1'b0, 32'h20, 1'b0, 1'b1, 32'h100);
        step();
        tests_run++; if (IR !== NOP || fetch_valid !== 1'b0 || PC_plus_4 !== 32'h20) begin tests_failed++; $display("FAIL redir_bubble got %h/%b/%h exp %h/0/00000020", IR, fetch_valid, PC_plus_4, NOP); end
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin tests_failed++; $display("FAIL redir_addr_hold got %b/%h exp 1/00000020", imem_req, imem_addr); end
        drive(1'b0, 32'h20, 1'b0, 1'b0, 32'd0);
        step();
        tests_run++; if (imem_addr !== 32'h20 || IR !== NOP || fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_wait got %h/%h exp 00000020/%h", imem_addr, IR, NOP); end
        drive(1'b1, 32'h20, 1'b0, 1'b0, 32'd0);
        step();
        tests_run++; if (IR !== NOP || fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_drop got %h/%b exp %h/0", IR, fetch_valid, NOP); end
        tests_run++; if (imem_addr !== 32'h100) begin tests_failed++; $display("FAIL redir_target got %h exp 00000100", imem_addr); end
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
        step();
        tests_run++; if (IR !== mem(32'h100) || PC_plus_4 !== 32'h104 || fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL redir_data got %h/%h/%b exp %h/00000104/1", IR, PC_plus_4, fetch_valid, mem(32'h100)); end
    endtask

    task automatic test_redirect_stall_hold();
        drive(1'b1, 32'h104, 1'b1, 1'b0, 32'd0);
        step();
        tests_run++; if (imem_req !== 1'b0 || IR !== mem(32'h100)) begin tests_failed++; $display("FAIL hold_enter got %b/%h exp 0/%h", imem_req, IR, mem(32'h100)); end
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h103);
        step();
        tests_run++; if (IR !== NOP || fetch_valid !== 1'b0 || PC_plus_4 !== 32'h104) begin tests_failed++; $display("FAIL hold_redir_bubble got %h/%b/%h exp %h/0/00000104", IR, fetch_valid, PC_plus_4, NOP); end
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin tests_failed++; $display("FAIL hold_redir_addr got %b/%h exp 1/00000100", imem_req, imem_addr); end
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
        step();
        tests_run++; if (IR !== mem(32'h100) || PC_plus_4 !== 32'h104 || fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_redir_data got %h/%h/%b exp %h/00000104/1", IR, PC_plus_4, fetch_valid, mem(32'h100)); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 32'h104, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        tests_run++; if (IR !== NOP || fetch_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_redir got %h/%b/%h exp %h/0/fffffffc", IR, fetch_valid, imem_addr, NOP); end
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
        step();
        tests_run++; if (IR !== mem(32'hFFFF_FFFC) || PC_plus_4 !== 32'd0 || fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_pc4 got %h/%h/%b exp %h/00000000/1", IR, PC_plus_4, fetch_valid, mem(32'hFFFF_FFFC)); end
        tests_run++; if (imem_addr !== 32'd0) begin tests_failed++; $display("FAIL wrap_addr got %h exp 00000000", imem_addr); end
    endtask

    task automatic test_reset_mid_drop();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
        // Put a real instruction on IR first? IR is already a bubble here; use
        // the pending target to prove the reset clears it.
        #2;
        reset = 1'b1;
        #1;
        tests_run++; if (IR !== NOP || fetch_valid !== 1'b0 || imem_req !== 1'b0 || PC_plus_4 !== 32'd0) begin tests_failed++; $display("FAIL rstdrop_async got %h/%b/%b/%h exp %h/0/0/0", IR, fetch_valid, imem_req, PC_plus_4, NOP); end
        step();
        reset = 1'b0;
        #1;
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin tests_failed++; $display("FAIL rstdrop_addr got %b/%h exp 1/%h", imem_req, imem_addr, RST_PC); end
        drive(1'b1, RST_PC, 1'b0, 1'b0, 32'd0);
        step();
        tests_run++; if (IR !== mem(RST_PC) || PC_plus_4 !== RST_PC + 32'd4 || fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL rstdrop_fetch got %h/%h/%b exp %h/%h/1", IR, PC_plus_4, fetch_valid, mem(RST_PC), RST_PC + 32'd4); end
        tests_run++; if (imem_addr !== RST_PC + 32'd4) begin tests_failed++; $display("FAIL rstdrop_next got %h exp %h", imem_addr, RST_PC + 32'd4); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_latency();
        test_redirect();
        test_redirect_stall_hold();
        test_wrap();
        test_reset_mid_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline. It sits directly upstream of the IF/ID pipeline register.
- Holds the fetch PC and issues requests to instruction memory over a req/ack handshake.
- Produces the PC_plus_4/IR pair that IF/ID captures every cycle.
- Handles load-use stalls by re-presenting the same instruction, since IF/ID has no enable. Handles branch/jump redirects by inserting NOP bubbles and discarding any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0000, bubble instruction presented on IR

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
stall  input  1  ID hazard unit: hold the current IR/PC_plus_4 outputs
redirect_valid  input  1  taken branch/jump resolved downstream; flush and refetch
redirect_pc  input  32  redirect target; bits [1:0] forced to 0
imem_req  output  1  fetch request
imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ack=0
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  fetched instruction
PC_plus_4  output  32  registered; address of presented instruction + 4
IR  output  32  registered; presented instruction
fetch_valid  output  1  registered; 1 = IR is a real instruction, 0 = bubble

Behaviour:
- Reset is asynchronous, active-high; clock clk.
- Reset values: state=S_FETCH, fetch_pc=RESET_PC, pending_pc=0, hold_ir=0, hold_pc4=0, IR=NOP_INSTR, PC_plus_4=0, fetch_valid=0.
- imem_req is forced 0 while reset=1.
- Internal registers: fetch_pc (address of the current/next request), pending_pc, hold_ir, hold_pc4, and a 2-bit state.
- State encoding: S_FETCH, S_HOLD, S_DROP.
- Combinational outputs:
  - imem_req = (state==S_FETCH || state==S_DROP).
  - imem_addr = fetch_pc.
- Priority: reset > redirect_valid > stall > normal flow.
- Zero-wait memory: ack in the same cycle as req gives 1 instruction/cycle. Latency is 1 cycle from ack to IR.
- Adder: fetch_pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- S_FETCH:
  - ack, !stall: IR<=imem_rdata, PC_plus_4<=fetch_pc+4, fetch_valid<=1, fetch_pc<=fetch_pc+4; stay in S_FETCH.
  - ack, stall: outputs hold; hold_ir<=imem_rdata, hold_pc4<=fetch_pc+4, fetch_pc<=fetch_pc+4; go to S_HOLD.
  - !ack, stall: outputs hold.
  - !ack, !stall: bubble, i.e. IR<=NOP_INSTR, fetch_valid<=0, PC_plus_4 holds.
- S_HOLD (no request issued):
  - stall: outputs hold.
  - !stall: IR<=hold_ir, PC_plus_4<=hold_pc4, fetch_valid<=1; go to S_FETCH.
- S_DROP (an in-flight request whose data must be discarded):
  - ack: data dropped; fetch_pc<=pending_pc; go to S_FETCH.
  - Outputs: hold if stall, else bubble.
- Redirect (any state) forces a bubble next cycle, overriding stall: IR<=NOP_INSTR, fetch_valid<=0, PC_plus_4 holds. Then:
  - S_FETCH with !ack: pending_pc<=redirect_pc; go to S_DROP. imem_addr stays at the old fetch_pc until ack.
  - S_FETCH with ack: data dropped; fetch_pc<=redirect_pc; stay in S_FETCH.
  - S_HOLD: hold_ir discarded; fetch_pc<=redirect_pc; go to S_FETCH.
  - S_DROP with !ack: pending_pc<=redirect_pc (latest redirect wins); stay in S_DROP.
  - S_DROP with ack: fetch_pc<=redirect_pc; go to S_FETCH.
- Reset mid-request: state returns to S_FETCH at RESET_PC. The outstanding ack is not tracked; the memory must also be reset.
- imem_ack while imem_req=0 is ignored.

Test Plan:
- Reset release, zero-wait memory with ack=1 every cycle, rdata=addr^32'hA5A5_0000 -> imem_addr 0,4,8,…; IR follows one cycle later; PC_plus_4=4,8,12; fetch_valid=1 from the 2nd cycle.
- 2-cycle memory latency -> after each ack, IR=NOP_INSTR/fetch_valid=0 for 1 cycle; imem_addr is stable while ack=0.
- stall high for 3 cycles, coinciding with an ack at addr 0x10 -> IR/PC_plus_4 frozen at the 0xC instruction for 3 cycles; state S_HOLD; no req; then IR=mem[0x10], PC_plus_4=0x14; next req at 0x14.
- redirect_valid with redirect_pc=0x100 while a req at 0x20 has no ack -> bubble; imem_addr stays 0x20 until ack; that data is dropped; next req at 0x100; IR=mem[0x100] with PC_plus_4=0x104.
- redirect and stall in the same cycle, in S_HOLD -> bubble (redirect wins); held instruction discarded; next req at redirect_pc. Also redirect_pc=0x103 -> fetch at 0x100.
- fetch_pc=32'hFFFF_FFFC -> PC_plus_4=0 and next imem_addr=0. Assert reset mid-S_DROP -> IR=NOP_INSTR, fetch_valid=0, next imem_addr=RESET_PC.
